dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 32-bit data words (power of two, at most 2^30).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted between request acceptance and response (0..15).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port req, input, 1 bit: the initiator requests an access.
REQ-007 SHALL have port we, input, 1 bit: 1 means store, 0 means load, sampled with req.
REQ-008 SHALL have port addr, input, 32 bits: byte address, sampled with req.
REQ-009 SHALL have port wdata, input, 32 bits: store data, sampled with req.
REQ-010 SHALL have port ready, output, 1 bit: the responder can accept a request this cycle.
REQ-011 SHALL have port ack, output, 1 bit: one-cycle response strobe.
REQ-012 SHALL have port rdata, output, 32 bits: load data, valid when ack is high and the access was a load.
REQ-013 SHALL have port err, output, 1 bit: the access was rejected, valid with ack.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, WAIT and RESP.
REQ-015 SHALL drive ready=1 only in IDLE; outputs SHALL be registered or decoded from state only, with no combinational path from req to ack.
REQ-016 SHALL accept a request on a rising edge where req=1 and ready=1, capturing we, addr and wdata into internal registers; the inputs are don't-care afterwards.
REQ-017 On acceptance, SHALL go IDLE->WAIT and load the wait counter with WAIT_CYCLES-1 when WAIT_CYCLES>0; when WAIT_CYCLES=0, SHALL go IDLE->RESP directly.
REQ-018 In WAIT, SHALL decrement the counter each cycle and go WAIT->RESP on the edge where the counter is 0.
REQ-019 Total latency, from the accepting edge to ack high, SHALL be WAIT_CYCLES+1 cycles.
REQ-020 In RESP, SHALL drive ack=1 for exactly one cycle, then go RESP->IDLE unconditionally.
REQ-021 A new request SHALL NOT be accepted before the cycle after ack; back-to-back throughput SHALL be one access per WAIT_CYCLES+2 cycles.
REQ-022 Word index SHALL be addr[log2(DEPTH)+1:2].
REQ-023 A request SHALL be an error when addr[1:0]!=0 or addr>=4*DEPTH.
REQ-024 On an error, SHALL respond with err=1 and ack=1 after the normal latency, SHALL NOT write memory, and SHALL drive rdata=0.
REQ-025 A valid store SHALL write the captured wdata to memory on the edge entering RESP, with err=0; rdata SHALL keep its previous value.
REQ-026 A valid load SHALL register mem[index] into rdata on the edge entering RESP, with err=0.
REQ-027 A load that follows a store to the same address SHALL return the stored data.
REQ-028 rdata and err SHALL hold their values until the next response; ack SHALL be the only strobe.
REQ-029 req while not ready SHALL be ignored, with no queuing.
REQ-030 Memory SHALL be word-granular only; there SHALL be no byte enables.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, counter 0, ack=0, err=0, rdata=0, ready=1, and clear the captured request registers.
REQ-032 Memory array contents SHALL NOT be reset; reads of never-written words SHALL return an unspecified value, and the bench SHALL initialise memory before reading.
REQ-033 Reset asserted in WAIT or RESP SHALL abort the access: no memory write, no ack after release.
REQ-034 After rst_n deasserts, a request SHALL be accepted on the first rising edge with req=1.

Verification
REQ-035 Store/load: WAIT_CYCLES=2, store addr=0x10, wdata=0xDEADBEEF, then load addr=0x10 -> each ack exactly 3 cycles after acceptance, load rdata=0xDEADBEEF, err=0.
REQ-036 Misaligned: load addr=0x13 -> ack with err=1, rdata=0; a subsequent load of 0x10 still returns 0xDEADBEEF.
REQ-037 Out of range: store addr=0x100 with DEPTH=64 -> err=1; word 0 (addr 0x0) unchanged.
REQ-038 Busy: req held high continuously -> ready low during WAIT/RESP; exactly one ack per 4 cycles; no lost or duplicate accesses.
REQ-039 Reset abort: store accepted to 0x20, rst_n pulsed low during WAIT -> no ack; a later load of 0x20 returns the prior contents.
REQ-040 Zero wait: WAIT_CYCLES=0, load addr=0x4 -> ack on the cycle after acceptance, with correct data.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder -- single-port data-memory responder with a fixed access latency.
//
// An access is accepted on a rising edge where req=1 and ready=1. The request
// (we/addr/wdata) is captured, WAIT_CYCLES wait states elapse, and then ack
// pulses for one cycle. A store writes memory, and a load registers the
// addressed word into rdata, on the edge that enters the response state.
// Misaligned or out-of-range addresses are rejected with err=1 and rdata=0.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   req    in   1  access request
//   we     in   1  1 = store, 0 = load (sampled with req)
//   addr   in  32  byte address (sampled with req)
//   wdata  in  32  store data (sampled with req)
//   ready  out  1  responder idle, can accept this cycle
//   ack    out  1  one-cycle response strobe
//   rdata  out 32  load data, held until the next response
//   err    out  1  access rejected, held until the next response
module dmem_responder #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned LOG2_DEPTH = $clog2(DEPTH);
    localparam int unsigned IDX_W      = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
    localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Rejects misaligned addresses and addresses beyond the last word.
    // The limit is formed in 64 bits so DEPTH = 2^30 does not overflow.
    function automatic logic addr_error(input logic [31:0] a);
        logic [63:0] limit;
        limit = 64'(DEPTH) << 2;
        return (a[1:0] != 2'b00) || ({32'd0, a} >= limit);
    endfunction

    state_t             state_r;
    state_t             next_state_s;
    logic [3:0]         cnt_r;
    logic [3:0]         cnt_next_s;

    logic               we_r;
    logic [31:0]        addr_r;
    logic [31:0]        wdata_r;

    logic               ack_r;
    logic               err_r;
    logic               ready_r;
    logic [31:0]        rdata_r;

    logic               op_we_s;
    logic [31:0]        op_addr_s;
    logic [31:0]        op_wdata_s;
    logic               op_err_s;
    logic [IDX_W-1:0]   op_idx_s;
    logic               accept_s;
    logic               enter_resp_s;
    logic               mem_we_s;

    logic [31:0]        mem_r [DEPTH];

    assign ready = ready_r;
    assign ack   = ack_r;
    assign err   = err_r;
    assign rdata = rdata_r;

    assign accept_s = req && (state_r == ST_IDLE);

    // Operand select: with zero wait states the response is formed on the
    // accepting edge itself, before the capture registers hold the request,
    // so the live inputs are used while idle.
    always_comb begin
        op_we_s    = we_r;
        op_addr_s  = addr_r;
        op_wdata_s = wdata_r;
        if (state_r == ST_IDLE) begin
            op_we_s    = we;
            op_addr_s  = addr;
            op_wdata_s = wdata;
        end else begin
            op_we_s    = we_r;
            op_addr_s  = addr_r;
            op_wdata_s = wdata_r;
        end
    end

    assign op_err_s     = addr_error(op_addr_s);
    assign op_idx_s     = op_addr_s[IDX_W+1:2];
    assign enter_resp_s = (next_state_s == ST_RESP);
    assign mem_we_s     = enter_resp_s && op_we_s && !op_err_s;

    // Next-state and wait-counter logic.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        next_state_s = ST_RESP;
                        cnt_next_s   = 4'd0;
                    end else begin
                        next_state_s = ST_WAIT;
                        cnt_next_s   = WAIT_LOAD;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                    cnt_next_s   = cnt_r;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = ST_RESP;
                    cnt_next_s   = 4'd0;
                end else begin
                    next_state_s = ST_WAIT;
                    cnt_next_s   = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                next_state_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Request capture; inputs are don't-care once the access is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
        end else if (accept_s) begin
            we_r    <= we;
            addr_r  <= addr;
            wdata_r <= wdata;
        end else begin
            we_r    <= we_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Registered response outputs; rdata/err only change when a response forms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            ready_r <= 1'b1;
            rdata_r <= 32'd0;
        end else begin
            ack_r   <= enter_resp_s;
            ready_r <= (next_state_s == ST_IDLE);
            if (enter_resp_s) begin
                err_r <= op_err_s;
                if (op_err_s) begin
                    rdata_r <= 32'd0;
                end else if (!op_we_s) begin
                    rdata_r <= mem_r[op_idx_s];
                end else begin
                    rdata_r <= rdata_r;
                end
            end else begin
                err_r   <= err_r;
                rdata_r <= rdata_r;
            end
        end
    end

    // Memory array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[op_idx_s] <= op_wdata_s;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: one instance with two wait states and one with
// zero wait states share clock and reset. A word-array model per instance
// predicts err/rdata, and latency is predicted from WAIT_CYCLES.
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;

    logic        req2 = 1'b0, we2 = 1'b0;
    logic [31:0] addr2 = 32'd0, wdata2 = 32'd0;
    logic        ready2, ack2, err2;
    logic [31:0] rdata2;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
    logic        ready0, ack0, err0;
    logic [31:0] rdata0;

    int errors = 0;
    int checks = 0;

    // Model state: index 0 = zero-wait instance, index 1 = two-wait instance.
    logic [31:0] mdl     [2][DEPTH];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
        .ready(ready2), .ack(ack2), .rdata(rdata2), .err(err2)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .ready(ready0), .ack(ack0), .rdata(rdata0), .err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ready(input int z);
        return (z == 0) ? ready0 : ready2;
    endfunction
    function automatic logic get_ack(input int z);
        return (z == 0) ? ack0 : ack2;
    endfunction
    function automatic logic get_err(input int z);
        return (z == 0) ? err0 : err2;
    endfunction
    function automatic logic [31:0] get_rdata(input int z);
        return (z == 0) ? rdata0 : rdata2;
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0)
            return 32'(4 * DEPTH) + (32'($urandom_range(0, 1023)) << 2);
        else if (r == 1)
            return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        else
            return 32'($urandom_range(0, DEPTH - 1)) << 2;
    endfunction

    // One complete access. Latency is counted in edges after the accepting
    // edge (sampled 1 time unit after each edge): ack appears right after the
    // accepting edge plus WAIT_CYCLES, i.e. in cycle WAIT_CYCLES+1.
    task automatic access(input int z, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int   lat_exp;
        int   found;
        logic bad;
        int   idx;
        lat_exp = (z == 0) ? 0 : 2;
        @(negedge clk);
        chk({tag, "/ready_before"}, {31'd0, get_ready(z)}, 32'd1);
        if (z == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d; end
        @(posedge clk); #1;
        if (z == 0) begin req0 = 1'b0; we0 = 1'($urandom); addr0 = $urandom; wdata0 = $urandom; end
        else        begin req2 = 1'b0; we2 = 1'($urandom); addr2 = $urandom; wdata2 = $urandom; end
        found = -1;
        for (int k = 0; k <= 20; k++) begin
            if (get_ack(z)) begin
                found = k;
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, "/latency"}, 32'(found), 32'(lat_exp));
        bad = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
        idx = int'(a >> 2);
        if (bad)    last_rd[z] = 32'd0;
        else if (w) mdl[z][idx] = d;
        else        last_rd[z] = mdl[z][idx];
        chk({tag, "/err"}, {31'd0, get_err(z)}, {31'd0, bad});
        chk({tag, "/rdata"}, get_rdata(z), last_rd[z]);
        @(posedge clk); #1;
        chk({tag, "/ack_one_cycle"}, {31'd0, get_ack(z)}, 32'd0);
        chk({tag, "/ready_after"}, {31'd0, get_ready(z)}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr_at [17];
        logic [31:0] d;
        logic [31:0] prior;
        int          ack_count;
        logic        saw_ack;

        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;

        // Reset values while rst_n is low.
        #2 rst_n = 1'b0;
        #1;
        for (int z = 0; z < 2; z++) begin
            chk("reset/ready", {31'd0, get_ready(z)}, 32'd1);
            chk("reset/ack",   {31'd0, get_ack(z)},   32'd0);
            chk("reset/err",   {31'd0, get_err(z)},   32'd0);
            chk("reset/rdata", get_rdata(z),          32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fill both memories; the first access also shows acceptance on the
        // first edge with req after reset release.
        for (int i = 0; i < DEPTH; i++) access(1, 1'b1, 32'(i) << 2, $urandom, "init2");
        for (int i = 0; i < DEPTH; i++) access(0, 1'b1, 32'(i) << 2, $urandom, "init0");

        // Store then load, two wait states.
        access(1, 1'b1, 32'h10, 32'hDEADBEEF, "store10");
        access(1, 1'b0, 32'h10, 32'h0, "load10");
        chk("load10/value", rdata2, 32'hDEADBEEF);

        // Misaligned load, then the good word is still intact.
        access(1, 1'b0, 32'h13, 32'h0, "load13");
        chk("load13/err_value", {31'd0, err2}, 32'd1);
        access(1, 1'b0, 32'h10, 32'h0, "reload10");
        chk("reload10/value", rdata2, 32'hDEADBEEF);

        // Out-of-range store must not alias onto word 0.
        access(1, 1'b1, 32'h100, $urandom, "store100");
        chk("store100/err_value", {31'd0, err2}, 32'd1);
        access(1, 1'b0, 32'h0, 32'h0, "load0");

        // Randomized mix on both instances.
        for (int i = 0; i < 40; i++) access(1, 1'($urandom), rand_addr(), $urandom, "rand2");
        for (int i = 0; i < 30; i++) access(0, 1'($urandom), rand_addr(), $urandom, "rand0");

        // Busy: req held high with fresh load addresses each cycle. Accepts
        // happen every WAIT_CYCLES+2 = 4 edges starting at edge 0.
        ack_count = 0;
        @(negedge clk);
        req2 = 1'b1; we2 = 1'b0;
        addr2 = 32'($urandom_range(0, DEPTH - 1)) << 2;
        addr_at[0] = addr2;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            chk("busy/ready", {31'd0, ready2}, {31'd0, ((n % 4) == 3)});
            chk("busy/ack",   {31'd0, ack2},   {31'd0, ((n % 4) == 2)});
            if (ack2) begin
                ack_count++;
                last_rd[1] = mdl[1][addr_at[n - 2] >> 2];
                chk("busy/rdata", rdata2, last_rd[1]);
                chk("busy/err", {31'd0, err2}, 32'd0);
            end
            @(negedge clk);
            if (n < 15) begin
                addr2 = 32'($urandom_range(0, DEPTH - 1)) << 2;
                addr_at[n + 1] = addr2;
            end else begin
                req2 = 1'b0;
            end
        end
        chk("busy/ack_count", 32'(ack_count), 32'd4);

        // Reset abort: store accepted to 0x20, reset pulsed during WAIT.
        prior = mdl[1][8];
        d = $urandom;
        if (d == prior) d = ~prior;
        @(negedge clk);
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h20; wdata2 = d;
        @(posedge clk); #1;
        req2 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort/ready_in_reset", {31'd0, ready2}, 32'd1);
        chk("abort/ack_in_reset",   {31'd0, ack2},   32'd0);
        chk("abort/rdata_in_reset", rdata2,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        saw_ack = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (ack2) saw_ack = 1'b1;
        end
        chk("abort/no_ack", {31'd0, saw_ack}, 32'd0);
        access(1, 1'b0, 32'h20, 32'h0, "abort_load20");
        chk("abort/prior_value", rdata2, prior);

        // Zero wait states: store then load at 0x4.
        d = $urandom;
        access(0, 1'b1, 32'h4, d, "zw_store4");
        access(0, 1'b0, 32'h4, 32'h0, "zw_load4");
        chk("zw_load4/value", rdata0, d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
